// File: rtl/game_round_ctrl.sv
// Whack-a-mole round sequencer: gap, random lane, armed window, then score/lives update from the checker verdict.
// All outputs registered; a verdict lands on score/lives one cycle after it is seen.
module game_round_ctrl #(
  parameter int unsigned WINDOW_CYCLES = 50000000,
  parameter int unsigned GAP_CYCLES    = 12500000,
  parameter int unsigned INIT_LIVES    = 3,
  parameter int unsigned SCORE_W       = 8,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_n,
  input  logic               button1,
  input  logic               button2,
  input  logic               button3,
  input  logic               button4,
  input  logic [1:0]         give_point_life,
  output logic [1:0]         random_num,
  output logic               start_checks,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic               point_pulse,
  output logic               life_pulse,
  output logic               game_over
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [2:0]       LIVES_INIT = 3'(INIT_LIVES);

  typedef enum logic [2:0] {IDLE, RELEASE, GAP, ARMED, OVER} state_t;

  state_t             state_q;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic [WIN_W-1:0]   win_cnt_q;
  logic [1:0]         rnd_q;
  logic               armed_q;
  logic [SCORE_W-1:0] score_q;
  logic [2:0]         lives_q;
  logic               point_q;
  logic               life_q;
  logic               over_q;

  logic hit, miss, all_up;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign hit    = (give_point_life == 2'b11);
  assign miss   = (give_point_life == 2'b01);
  assign all_up = start_n & button1 & button2 & button3 & button4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lfsr_q    <= LFSR_SEED;
      gap_cnt_q <= '0;
      win_cnt_q <= '0;
      rnd_q     <= 2'b00;
      armed_q   <= 1'b0;
      score_q   <= '0;
      lives_q   <= LIVES_INIT;
      point_q   <= 1'b0;
      life_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      point_q <= 1'b0;
      life_q  <= 1'b0;
      case (state_q)
        IDLE, OVER: begin
          if (!start_n) begin
            score_q <= '0;
            lives_q <= LIVES_INIT;
            over_q  <= 1'b0;
            state_q <= RELEASE;
          end
        end
        // Wait for every button to be up so a held press cannot score next round
        RELEASE: begin
          if (all_up) begin
            gap_cnt_q <= '0;
            state_q   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            rnd_q     <= lfsr_q[1:0];
            win_cnt_q <= '0;
            armed_q   <= 1'b1;
            state_q   <= ARMED;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        ARMED: begin
          if (hit) begin
            if (score_q != {SCORE_W{1'b1}}) score_q <= score_q + 1'b1;
            point_q <= 1'b1;
            armed_q <= 1'b0;
            state_q <= RELEASE;
          end else if (miss || (win_cnt_q == WIN_LAST)) begin
            lives_q <= lives_q - 3'd1;
            life_q  <= 1'b1;
            armed_q <= 1'b0;
            if (lives_q == 3'd1) begin
              over_q  <= 1'b1;
              state_q <= OVER;
            end else begin
              state_q <= RELEASE;
            end
          end else begin
            win_cnt_q <= win_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign random_num   = rnd_q;
  assign start_checks = armed_q;
  assign score        = score_q;
  assign lives        = lives_q;
  assign point_pulse  = point_q;
  assign life_pulse   = life_q;
  assign game_over    = over_q;

endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Sequencer for the whack-a-mole hit checker; owns game state: start, rounds, score, lives, game over.
- Each round: waits a gap, picks a target lane (0-3) from a free-running LFSR, then arms the checker with `start_checks`.
- Consumes the checker's `give_point_life` verdict, or times the round out, and updates score/lives.
- Sits between the board push-buttons and the checker; drives the score/lives display logic.

Parameters:
- WINDOW_CYCLES, 50000000, max cycles `start_checks` stays high per round (1 s at 50 MHz); must be >= 2.
- GAP_CYCLES, 12500000, idle cycles between rounds with all lights off; must be >= 1.
- INIT_LIVES, 3, lives loaded at game start; 1..7.
- SCORE_W, 8, score counter width.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start_n  input  1  start/restart button, active-low
- button1  input  1  lane 0 button, active-low
- button2  input  1  lane 1 button, active-low
- button3  input  1  lane 2 button, active-low
- button4  input  1  lane 3 button, active-low
- give_point_life  input  2  checker verdict: 2'b11 hit, 2'b01 wrong button, other values mean none
- random_num  output  2  target lane to checker, registered
- start_checks  output  1  arms checker, registered
- score  output  SCORE_W  points this game
- lives  output  3  remaining lives
- point_pulse  output  1  one-cycle pulse on score increment
- life_pulse  output  1  one-cycle pulse on life loss (wrong button or timeout)
- game_over  output  1  high in OVER state

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - state IDLE; score 0; lives INIT_LIVES; random_num 2'b00.
  - start_checks 0, point_pulse 0, life_pulse 0, game_over 0.
  - gap and window counters 0; LFSR LFSR_SEED.
- Reset asserted in any state returns everything to these values on the next edge; no verdict is applied in that cycle.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle in every state except reset.
  - random_num loads LFSR[1:0] only on the GAP->ARMED transition; it is stable for the whole of ARMED.
- Buttons and start_n are used as already synchronised; no debounce here.
- FSM:
  - IDLE: start_checks=0. On start_n==0: score<=0, lives<=INIT_LIVES, go to RELEASE.
  - RELEASE: start_checks=0. Stays until start_n and button1..4 are all 1 in the same cycle, then clears the gap counter and goes to GAP. This prevents a held button counting in the next round.
  - GAP:
    - Counts GAP_CYCLES cycles.
    - In the last cycle: latch random_num, clear the window counter, go to ARMED.
    - A button press during GAP is ignored.
  - ARMED: start_checks=1 from the first ARMED cycle. Each cycle, in priority order:
    1. give_point_life==2'b11: score+1 (saturates at all-ones; point_pulse still fires), point_pulse=1, go to RELEASE.
    2. give_point_life==2'b01: lives-1, life_pulse=1; go to OVER if the new lives==0, else RELEASE.
    3. Window counter == WINDOW_CYCLES-1: timeout, handled exactly as case 2.
    4. Otherwise increment the window counter.
    - A verdict in the same cycle as the timeout wins; a hit in the final cycle scores.
    - 2'b00 and 2'b10 are treated as no verdict.
  - OVER: start_checks=0, game_over=1. score and lives hold. start_n==0 restarts exactly as from IDLE (game_over drops next cycle).
- start_checks drops in the cycle after a verdict or timeout. Verdicts arriving outside ARMED are ignored.
- point_pulse and life_pulse are never both high.
- lives never underflows: OVER is entered at 0, and no decrement occurs outside ARMED.
- Latency:
  - start press to first ARMED cycle = 1 (IDLE->RELEASE) + release wait + 1 + GAP_CYCLES.
  - Verdict to score/lives update = 1 cycle.

Test Plan (WINDOW_CYCLES=20, GAP_CYCLES=4, INIT_LIVES=3, SCORE_W=8):
- Reset then idle 50 cycles -> score=0, lives=3, start_checks=0, game_over=0; start_checks never rises without a start press.
- Pulse start_n low 1 cycle, buttons high -> RELEASE then GAP; start_checks=1 exactly 4 cycles after entering GAP, with random_num equal to the LFSR[1:0] value predicted by the model.
- In ARMED, drive give_point_life=2'b11 for 1 cycle -> score=1 and point_pulse=1 next cycle, start_checks=0; hold button1 low 10 cycles -> FSM stays in RELEASE, no new round.
- Drive 2'b01 three times across three rounds -> lives 3->2->1->0, three life_pulses, game_over=1 after the third; further verdicts change nothing.
- No verdict for 20 ARMED cycles -> life_pulse on the 20th cycle and lives decremented; a variant driving 2'b11 on that same cycle -> score+1, lives unchanged.
- Assert rst mid-ARMED with a verdict present -> next cycle start_checks=0, score=0, lives=3, state IDLE; also preload score=255 and hit once -> score stays 255 with point_pulse=1.
